// File: rtl/dlx_isa_pkg.sv
// DLX ISA definitions shared by the instruction encoder and the control decoder.
// Bit numbering is big-endian: bit 0 is the MSB of every field.
package dlx_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_FPR = 2'b11
  } fmt_e;

  localparam logic [0:5]  OP_RTYPE = 6'b000000;
  localparam logic [0:5]  OP_FPR   = 6'b000001;
  localparam logic [0:31] NOP_WORD = 32'h0000_0000;

  localparam int OPC_LO   = 0;
  localparam int OPC_HI   = 5;
  localparam int RS1_LO   = 6;
  localparam int RS1_HI   = 10;
  localparam int RS2_LO   = 11;
  localparam int RS2_HI   = 15;
  localparam int RD_LO    = 16;
  localparam int RD_HI    = 20;
  localparam int SPARE_LO = 21;
  localparam int SPARE_HI = 25;
  localparam int FUNC_LO  = 26;
  localparam int FUNC_HI  = 31;
  localparam int IRD_LO   = 11;
  localparam int IRD_HI   = 15;
  localparam int IMM16_LO = 16;
  localparam int IMM16_HI = 31;
  localparam int IMM26_LO = 6;
  localparam int IMM26_HI = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PAD  = 3'd2,
    ST_TERM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // J, JAL, JR, JALR: the decoder matches the same sparse opcode pattern.
  function automatic logic is_jump(input logic [0:5] op);
    return ~op[0] & ~op[2] & ~op[3] & op[4];
  endfunction

  function automatic logic is_branch(input logic [0:5] op);
    return (op[0:4] == 5'b00010);
  endfunction

endpackage

// File: rtl/dlx_field_packer.sv
// Combinational packing of a DLX instruction descriptor into a 32-bit word,
// plus the control-transfer flag that triggers delay-slot padding.
module dlx_field_packer
  import dlx_isa_pkg::*;
(
  input  logic [0:1]  fmt,
  input  logic [0:5]  opcode,
  input  logic [0:5]  func,
  input  logic [0:4]  rs1,
  input  logic [0:4]  rs2,
  input  logic [0:4]  rd,
  input  logic [0:25] imm,
  output logic [0:31] word,
  output logic        ctrl_xfer
);

  fmt_e fmt_s;
  assign fmt_s = fmt_e'(fmt);

  // Field placement per instruction format.
  always_comb begin
    word = NOP_WORD;
    case (fmt_s)
      FMT_R: begin
        word[OPC_LO:OPC_HI]     = OP_RTYPE;
        word[RS1_LO:RS1_HI]     = rs1;
        word[RS2_LO:RS2_HI]     = rs2;
        word[RD_LO:RD_HI]       = rd;
        word[SPARE_LO:SPARE_HI] = 5'b00000;
        word[FUNC_LO:FUNC_HI]   = func;
      end
      FMT_FPR: begin
        word[OPC_LO:OPC_HI]       = OP_FPR;
        word[RS1_LO:RS1_HI]       = rs1;
        word[RS2_LO:RS2_HI]       = rs2;
        word[RD_LO:RD_HI]         = rd;
        word[SPARE_LO:SPARE_HI]   = 5'b00000;
        word[FUNC_LO]             = 1'b0;
        word[FUNC_LO+1:FUNC_HI]   = func[1:5];
      end
      FMT_I: begin
        word[OPC_LO:OPC_HI]     = opcode;
        word[RS1_LO:RS1_HI]     = rs1;
        word[IRD_LO:IRD_HI]     = rd;
        word[IMM16_LO:IMM16_HI] = imm[10:25];
      end
      FMT_J: begin
        word[OPC_LO:OPC_HI]     = opcode;
        word[IMM26_LO:IMM26_HI] = imm;
      end
      default: word = NOP_WORD;
    endcase
  end

  assign ctrl_xfer = ((fmt_s == FMT_I) || (fmt_s == FMT_J)) &&
                     (is_jump(opcode) || is_branch(opcode));

endmodule

// File: rtl/dlx_insn_encoder.sv
// Streams instruction descriptors into imem as packed DLX words, inserting delay-slot
// NOPs after control transfers and a zero terminator after the final instruction.
module dlx_insn_encoder
  import dlx_isa_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
  parameter int                DELAY_NOPS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:1]        in_fmt,
  input  logic [0:5]        in_opcode,
  input  logic [0:5]        in_func,
  input  logic [0:4]        in_rs1,
  input  logic [0:4]        in_rs2,
  input  logic [0:4]        in_rd,
  input  logic [0:25]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [0:31]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int               PAD_W    = (DELAY_NOPS > 1) ? $clog2(DELAY_NOPS + 1) : 1;
  localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'(DELAY_NOPS);
  localparam logic [PAD_W-1:0] PAD_ONE  = {{(PAD_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam bit               PAD_EN   = (DELAY_NOPS > 0);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   word_count_r;
  logic              overflow_r;
  logic [PAD_W-1:0]  pad_cnt_r;
  logic              last_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [0:31]       imem_wdata_r;
  logic [0:31]       word_s;
  logic              ctrl_s;
  logic              full_s;

  dlx_field_packer u_packer (
    .fmt       (in_fmt),
    .opcode    (in_opcode),
    .func      (in_func),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .rd        (in_rd),
    .imm       (in_imm),
    .word      (word_s),
    .ctrl_xfer (ctrl_s)
  );

  // Capacity is tracked by count, not address, so wrapped sessions stop correctly.
  assign full_s = (word_count_r == CAPACITY);

  // Session FSM, write port registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      word_count_r <= {(ADDR_W+1){1'b0}};
      overflow_r   <= 1'b0;
      pad_cnt_r    <= {PAD_W{1'b0}};
      last_r       <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= NOP_WORD;
    end else begin
      imem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_r       <= BASE_ADDR;
            word_count_r <= {(ADDR_W+1){1'b0}};
            overflow_r   <= 1'b0;
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            last_r <= in_last;
            if (full_s) begin
              overflow_r <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= addr_r;
              imem_wdata_r <= word_s;
              addr_r       <= addr_r + ADDR_ONE;
              word_count_r <= word_count_r + WC_ONE;
              if (PAD_EN && ctrl_s) begin
                pad_cnt_r <= PAD_INIT;
                state_r   <= ST_PAD;
              end else if (in_last) begin
                state_r <= ST_TERM;
              end
            end
          end
        end
        ST_PAD: begin
          if (full_s) begin
            overflow_r <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            imem_we_r    <= 1'b1;
            imem_addr_r  <= addr_r;
            imem_wdata_r <= NOP_WORD;
            addr_r       <= addr_r + ADDR_ONE;
            word_count_r <= word_count_r + WC_ONE;
            pad_cnt_r    <= pad_cnt_r - PAD_ONE;
            if (pad_cnt_r == PAD_ONE) begin
              state_r <= last_r ? ST_TERM : ST_LOAD;
            end
          end
        end
        ST_TERM: begin
          if (full_s) begin
            overflow_r <= 1'b1;
          end else begin
            imem_we_r    <= 1'b1;
            imem_addr_r  <= addr_r;
            imem_wdata_r <= NOP_WORD;
            addr_r       <= addr_r + ADDR_ONE;
            word_count_r <= word_count_r + WC_ONE;
          end
          state_r <= ST_DONE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_r == ST_LOAD);
  assign busy       = (state_r == ST_LOAD) || (state_r == ST_PAD) || (state_r == ST_TERM);
  assign done       = (state_r == ST_DONE);
  assign overflow   = overflow_r;
  assign word_count = word_count_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;

endmodule

// File: tb/tb_dlx_insn_encoder.sv
// Bench for dlx_insn_encoder: two configurations driven with directed and random
// descriptor sessions, checked against an arithmetic model of the expected imem writes.
module tb_dlx_insn_encoder;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  opc;
    logic [5:0]  func;
    logic [4:0]  rs1, rs2, rd;
    logic [25:0] imm;
    logic        last;
  } desc_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        t_start [2];
  logic        t_valid [2];
  logic [1:0]  t_fmt   [2];
  logic [5:0]  t_opc   [2];
  logic [5:0]  t_func  [2];
  logic [4:0]  t_rs1   [2];
  logic [4:0]  t_rs2   [2];
  logic [4:0]  t_rd    [2];
  logic [25:0] t_imm   [2];
  logic        t_last  [2];
  logic        ready_w [2];
  logic        we_w    [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        ovf_w   [2];
  logic [31:0] wdata_w [2];
  logic [9:0]  addr0;
  logic [1:0]  addr1;
  logic [10:0] wc0;
  logic [2:0]  wc1;

  int  cyc = 0;
  int  act = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  wr_t wq[$];
  int  hs[$];

  always #5 clk = ~clk;

  dlx_insn_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0), .DELAY_NOPS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(t_start[0]), .in_valid(t_valid[0]), .in_ready(ready_w[0]),
    .in_fmt(t_fmt[0]), .in_opcode(t_opc[0]), .in_func(t_func[0]), .in_rs1(t_rs1[0]),
    .in_rs2(t_rs2[0]), .in_rd(t_rd[0]), .in_imm(t_imm[0]), .in_last(t_last[0]),
    .imem_we(we_w[0]), .imem_addr(addr0), .imem_wdata(wdata_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .overflow(ovf_w[0]), .word_count(wc0));

  dlx_insn_encoder #(.ADDR_W(2), .BASE_ADDR(2'd2), .DELAY_NOPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(t_start[1]), .in_valid(t_valid[1]), .in_ready(ready_w[1]),
    .in_fmt(t_fmt[1]), .in_opcode(t_opc[1]), .in_func(t_func[1]), .in_rs1(t_rs1[1]),
    .in_rs2(t_rs2[1]), .in_rd(t_rd[1]), .in_imm(t_imm[1]), .in_last(t_last[1]),
    .imem_we(we_w[1]), .imem_addr(addr1), .imem_wdata(wdata_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .overflow(ovf_w[1]), .word_count(wc1));

  function automatic int cap_of(input int d);  return (d != 0) ? 4 : 1024; endfunction
  function automatic int base_of(input int d); return (d != 0) ? 2 : 0;    endfunction
  function automatic int nops_of(input int d); return (d != 0) ? 1 : 2;    endfunction
  function int wc_of(input int d);   return (d != 0) ? int'(wc1) : int'(wc0);     endfunction
  function int addr_of(input int d); return (d != 0) ? int'(addr1) : int'(addr0); endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    wr_t w;
    if (we_w[act]) begin
      w.addr = addr_of(act);
      w.data = wdata_w[act];
      w.cyc  = cyc;
      wq.push_back(w);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
    end
  endtask

  // Reference encoding with numeric (LSB-0) shifts; field [a:b] of the big-endian word
  // lands at numeric bit position 31-b.
  function automatic logic [31:0] enc(input desc_t x);
    case (x.fmt)
      2'd0: return (32'(x.rs1) << 21) | (32'(x.rs2) << 16) | (32'(x.rd) << 11) | 32'(x.func);
      2'd3: return (32'd1 << 26) | (32'(x.rs1) << 21) | (32'(x.rs2) << 16) | (32'(x.rd) << 11)
                   | (32'(x.func) & 32'h1F);
      2'd1: return (32'(x.opc) << 26) | (32'(x.rs1) << 21) | (32'(x.rd) << 16)
                   | (32'(x.imm) & 32'hFFFF);
      default: return (32'(x.opc) << 26) | (32'(x.imm) & 32'h03FF_FFFF);
    endcase
  endfunction

  function automatic bit is_ctrl(input desc_t x);
    if (x.fmt != 2'd1 && x.fmt != 2'd2) return 1'b0;
    return x.opc inside {6'h02, 6'h03, 6'h12, 6'h13, 6'h04, 6'h05};
  endfunction

  function automatic desc_t mk(input int f, input int op, input int fn, input int a,
                               input int b, input int r, input int im, input bit l);
    desc_t x;
    x.fmt = 2'(f); x.opc = 6'(op); x.func = 6'(fn); x.rs1 = 5'(a); x.rs2 = 5'(b);
    x.rd = 5'(r); x.imm = 26'(im); x.last = l;
    return x;
  endfunction

  function automatic desc_t rand_desc(input bit l);
    int op;
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 5))
        0: op = 6'h02;  1: op = 6'h03;  2: op = 6'h12;
        3: op = 6'h13;  4: op = 6'h04;  default: op = 6'h05;
      endcase
    end else begin
      op = int'($urandom_range(0, 63));
    end
    return mk(int'($urandom_range(0, 3)), op, int'($urandom_range(0, 63)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom), l);
  endfunction

  task automatic pulse_start(input int d);
    t_start[d] = 1'b1;
    @(posedge clk); #1;
    t_start[d] = 1'b0;
  endtask

  task automatic send(input int d, input desc_t x, input int gap, output bit ok);
    int n;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    t_fmt[d] = x.fmt; t_opc[d] = x.opc; t_func[d] = x.func; t_rs1[d] = x.rs1;
    t_rs2[d] = x.rs2; t_rd[d] = x.rd; t_imm[d] = x.imm; t_last[d] = x.last;
    t_valid[d] = 1'b1;
    n = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      if (ready_w[d]) begin
        hs.push_back(cyc);
        ok = 1'b1;
      end else if (done_w[d]) begin
        n = 64;
      end
      n++;
    end
    if (!ok && !done_w[d]) check_eq("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    t_valid[d] = 1'b0;
  endtask

  task automatic run_session(input int d, input desc_t q[$], input bit rnd_gap, input bit poke);
    logic [31:0] ed[$];
    int src[$], gaps[$];
    int total, nexp, n, g;
    bit ok;
    act = d;
    wq.delete();
    hs.delete();
    foreach (q[i]) begin
      ed.push_back(enc(q[i])); src.push_back(i);
      if (is_ctrl(q[i])) repeat (nops_of(d)) begin ed.push_back(32'd0); src.push_back(-1); end
      if (q[i].last) begin ed.push_back(32'd0); src.push_back(-1); end
    end
    total = ed.size();
    nexp  = (total > cap_of(d)) ? cap_of(d) : total;
    pulse_start(d);
    foreach (q[i]) begin
      g = rnd_gap ? int'($urandom_range(0, 2)) : 0;
      if (poke && i == 1) begin
        t_start[d] = 1'b1; @(posedge clk); #1; t_start[d] = 1'b0;
        g = g + 1;
      end
      gaps.push_back(g);
      send(d, q[i], (poke && i == 1) ? g - 1 : g, ok);
      if (!ok) break;
    end
    n = 0;
    while (!done_w[d] && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check_eq("done", 32'(done_w[d]), 32'd1);
    check_eq("busy_end", 32'(busy_w[d]), 32'd0);
    check_eq("ready_end", 32'(ready_w[d]), 32'd0);
    check_eq("n_writes", wq.size(), nexp);
    check_eq("word_count", wc_of(d), nexp);
    check_eq("overflow", 32'(ovf_w[d]), 32'(total > cap_of(d)));
    for (int k = 0; k < nexp && k < wq.size(); k++) begin
      check_eq("wdata", wq[k].data, ed[k]);
      check_eq("waddr", wq[k].addr, (base_of(d) + k) % cap_of(d));
      if (src[k] >= 0 && src[k] < hs.size()) check_eq("latency", wq[k].cyc, hs[src[k]] + 1);
    end
    for (int i = 0; i + 1 < hs.size(); i++) begin
      if (gaps[i+1] == 0)
        check_eq("stall", hs[i+1] - hs[i], is_ctrl(q[i]) ? nops_of(d) + 1 : 1);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    check_eq({tag, "_we"},    32'(we_w[d]), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready_w[d]), 32'd0);
    check_eq({tag, "_busy"},  32'(busy_w[d]), 32'd0);
    check_eq({tag, "_done"},  32'(done_w[d]), 32'd0);
    check_eq({tag, "_ovf"},   32'(ovf_w[d]), 32'd0);
    check_eq({tag, "_wdata"}, wdata_w[d], 32'd0);
    check_eq({tag, "_addr"},  addr_of(d), 32'd0);
    check_eq({tag, "_wc"},    wc_of(d), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin : main
    desc_t q[$];
    bit ok;
    for (int d = 0; d < 2; d++) begin
      t_start[d] = 1'b0; t_valid[d] = 1'b0; t_fmt[d] = 2'd0; t_opc[d] = 6'd0;
      t_func[d] = 6'd0; t_rs1[d] = 5'd0; t_rs2[d] = 5'd0; t_rd[d] = 5'd0;
      t_imm[d] = 26'd0; t_last[d] = 1'b0;
    end
    repeat (3) @(posedge clk); #1;
    chk_zero(0, "rst0"); chk_zero(1, "rst1");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero(0, "idle0");

    // ADD, ADDI, FPR MULT, J with two pads, R last, terminator.
    q.delete();
    q.push_back(mk(0, 0, 6'h20, 1, 2, 3, 0, 1'b0));
    q.push_back(mk(1, 6'h08, 0, 4, 0, 5, 26'hFFFF, 1'b0));
    q.push_back(mk(3, 0, 6'h0E, 1, 2, 3, 0, 1'b0));
    q.push_back(mk(2, 6'h02, 0, 0, 0, 0, 26'h100, 1'b0));
    q.push_back(mk(0, 0, 6'h22, 7, 8, 9, 0, 1'b1));
    run_session(0, q, 1'b0, 1'b0);
    if (wq.size() >= 8) begin
      check_eq("add_word",  wq[0].data, 32'h0022_1820);
      check_eq("addi_word", wq[1].data, 32'h2085_FFFF);
      check_eq("fpr_word",  wq[2].data, 32'h0422_180E);
      check_eq("j_word",    wq[3].data, 32'h0800_0100);
      check_eq("pad1_word", wq[4].data, 32'h0000_0000);
      check_eq("next_addr", wq[6].addr, 32'd6);
      check_eq("term_word", wq[7].data, 32'h0000_0000);
    end

    // Three R with last, plus a start pulse in LOAD that must be ignored.
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 6'h20 + i, i, i + 1, i + 2, 0, i == 2));
    run_session(0, q, 1'b0, 1'b1);
    check_eq("three_r_wc", 32'(wc0), 32'd4);

    // Small config: five descriptors overflow a 4-word memory starting at address 2.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(mk(0, 0, i, i, i, i, 0, i == 4));
    run_session(1, q, 1'b0, 1'b0);
    check_eq("small_ovf", 32'(ovf_w[1]), 32'd1);

    // Branch flagged last: pad precedes the terminator.
    q.delete();
    q.push_back(mk(1, 6'h04, 0, 3, 0, 0, 26'h0040, 1'b1));
    run_session(1, q, 1'b0, 1'b0);

    // Reset while padding after a jump, then a fresh session from the base address.
    act = 0; wq.delete(); hs.delete();
    pulse_start(0);
    send(0, mk(2, 6'h03, 0, 0, 0, 0, 26'h3_0000, 1'b0), 0, ok);
    @(negedge clk);
    check_eq("pad_ready", 32'(ready_w[0]), 32'd0);
    check_eq("pad_busy",  32'(busy_w[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_zero(0, "midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    q.delete();
    q.push_back(mk(0, 0, 6'h24, 10, 11, 12, 0, 1'b1));
    run_session(0, q, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int len;
      len = ((r % 2) != 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 8));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(rand_desc(i == len - 1));
      run_session(r % 2, q, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
